// File: rtl/alu_pkg.sv
// Op encoding and decode helpers shared by the integer execution pipeline.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_ADDI  = 5'd5,
        OP_ANDI  = 5'd6,
        OP_ORI   = 5'd7,
        OP_XORI  = 5'd8,
        OP_SLL   = 5'd9,
        OP_SRL   = 5'd10,
        OP_SRA   = 5'd11,
        OP_SLLI  = 5'd12,
        OP_SRLI  = 5'd13,
        OP_SRAI  = 5'd14,
        OP_SLT   = 5'd15,
        OP_SLTU  = 5'd16,
        OP_SLTI  = 5'd17,
        OP_SLTIU = 5'd18,
        OP_BEQ   = 5'd19,
        OP_BNE   = 5'd20,
        OP_BLT   = 5'd21,
        OP_BGE   = 5'd22,
        OP_BLTU  = 5'd23,
        OP_BGEU  = 5'd24,
        OP_LUI   = 5'd25,
        OP_AUIPC = 5'd26,
        OP_JAL   = 5'd27,
        OP_JALR  = 5'd28
    } op_e;

    // Wide enough for any legal XLEN; slice to width at the use site.
    localparam logic [63:0] ZERO = 64'd0;

    // Ops that report a branch resolution (conditional branches and jumps).
    function automatic logic is_branch(input logic [OP_W-1:0] op);
        logic br;
        case (op)
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
            OP_BLTU, OP_BGEU, OP_JAL, OP_JALR: br = 1'b1;
            default:                           br = 1'b0;
        endcase
        return br;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I ALU/branch compute: result value plus branch resolution.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pred_tk_i,
    output logic [XLEN-1:0] data_o,
    output logic            is_br_o,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic            mispred_o
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] pc4_s;
    logic [XLEN-1:0] pc_imm_s;
    logic [XLEN-1:0] a_imm_s;
    logic [SH_W-1:0] shb_s;
    logic [SH_W-1:0] shi_s;
    logic            lt_s;
    logic            ltu_s;
    logic            lti_s;
    logic            ltiu_s;
    logic            cond_s;

    assign pc4_s    = pc_i + XLEN'(3'd4);
    assign pc_imm_s = pc_i + imm_i;
    assign a_imm_s  = a_i + imm_i;
    assign shb_s    = b_i[SH_W-1:0];
    assign shi_s    = imm_i[SH_W-1:0];
    assign lt_s     = $signed(a_i) < $signed(b_i);
    assign ltu_s    = a_i < b_i;
    assign lti_s    = $signed(a_i) < $signed(imm_i);
    assign ltiu_s   = a_i < imm_i;

    // Conditional-branch predicate; zero for every non-Bxx op.
    always_comb begin
        case (op_i)
            OP_BEQ:  cond_s = (a_i == b_i);
            OP_BNE:  cond_s = (a_i != b_i);
            OP_BLT:  cond_s = lt_s;
            OP_BGE:  cond_s = ~lt_s;
            OP_BLTU: cond_s = ltu_s;
            OP_BGEU: cond_s = ~ltu_s;
            default: cond_s = 1'b0;
        endcase
    end

    // Result value and resolved next pc; non-taken ops fall through to pc+4.
    always_comb begin
        data_o   = ZERO[XLEN-1:0];
        taken_o  = 1'b0;
        target_o = pc4_s;
        case (op_i)
            OP_ADD:   data_o = a_i + b_i;
            OP_SUB:   data_o = a_i - b_i;
            OP_AND:   data_o = a_i & b_i;
            OP_OR:    data_o = a_i | b_i;
            OP_XOR:   data_o = a_i ^ b_i;
            OP_ADDI:  data_o = a_imm_s;
            OP_ANDI:  data_o = a_i & imm_i;
            OP_ORI:   data_o = a_i | imm_i;
            OP_XORI:  data_o = a_i ^ imm_i;
            OP_SLL:   data_o = a_i << shb_s;
            OP_SRL:   data_o = a_i >> shb_s;
            OP_SRA:   data_o = $unsigned($signed(a_i) >>> shb_s);
            OP_SLLI:  data_o = a_i << shi_s;
            OP_SRLI:  data_o = a_i >> shi_s;
            OP_SRAI:  data_o = $unsigned($signed(a_i) >>> shi_s);
            OP_SLT:   data_o = XLEN'(lt_s);
            OP_SLTU:  data_o = XLEN'(ltu_s);
            OP_SLTI:  data_o = XLEN'(lti_s);
            OP_SLTIU: data_o = XLEN'(ltiu_s);
            OP_LUI:   data_o = imm_i;
            OP_AUIPC: data_o = pc_imm_s;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                data_o   = XLEN'(cond_s);
                taken_o  = cond_s;
                target_o = cond_s ? pc_imm_s : pc4_s;
            end
            OP_JAL: begin
                data_o   = pc4_s;
                taken_o  = 1'b1;
                target_o = pc_imm_s;
            end
            OP_JALR: begin
                data_o   = pc4_s;
                taken_o  = 1'b1;
                target_o = {a_imm_s[XLEN-1:1], 1'b0};
            end
            default: begin
                data_o   = ZERO[XLEN-1:0];
                taken_o  = 1'b0;
                target_o = pc4_s;
            end
        endcase
    end

    assign is_br_o   = is_branch(op_i);
    assign mispred_o = is_br_o & (taken_o ^ pred_tk_i);

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer execution unit: compute before stage 1, then a STAGES-deep
// valid/payload shift register with whole-pipe stall and synchronous flush.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_pred_tk,
    input  logic [ROB_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [ROB_W-1:0] out_tag,
    output logic             out_is_br,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic             out_mispred
);

    // Payload layout: {data, tag, is_br, taken, target, mispred}
    localparam int PW = 2 * XLEN + ROB_W + 3;

    logic [XLEN-1:0] c_data_s;
    logic [XLEN-1:0] c_target_s;
    logic            c_is_br_s;
    logic            c_taken_s;
    logic            c_mispred_s;
    logic            stall_s;
    logic            accept_s;
    logic [PW-1:0]   pay_in_s;
    logic            stage_valid_s [STAGES];
    logic [PW-1:0]   stage_pay_s   [STAGES];

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .op_i      (in_op),
        .a_i       (in_a),
        .b_i       (in_b),
        .imm_i     (in_imm),
        .pc_i      (in_pc),
        .pred_tk_i (in_pred_tk),
        .data_o    (c_data_s),
        .is_br_o   (c_is_br_s),
        .taken_o   (c_taken_s),
        .target_o  (c_target_s),
        .mispred_o (c_mispred_s)
    );

    // Flush overrides a stall, so the unit keeps accepting during a flush cycle.
    assign stall_s  = stage_valid_s[STAGES-1] & ~out_ready;
    assign in_ready = flush | ~stall_s;
    assign accept_s = in_valid & in_ready & ~flush;
    assign pay_in_s = {c_data_s, in_tag, c_is_br_s, c_taken_s, c_target_s, c_mispred_s};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic          up_valid_s;
        logic [PW-1:0] up_pay_s;
        logic          valid_d;
        logic          valid_q;
        logic [PW-1:0] pay_d;
        logic [PW-1:0] pay_q;

        if (s == 0) begin : g_head
            assign up_valid_s = accept_s;
            assign up_pay_s   = pay_in_s;
        end else begin : g_body
            assign up_valid_s = stage_valid_s[s-1];
            assign up_pay_s   = stage_pay_s[s-1];
        end

        // Bubbles carry an all-zero payload so idle outputs read as zero.
        always_comb begin
            valid_d = valid_q;
            pay_d   = pay_q;
            if (flush) begin
                valid_d = 1'b0;
                pay_d   = {PW{1'b0}};
            end else if (!stall_s) begin
                valid_d = up_valid_s;
                pay_d   = up_valid_s ? up_pay_s : {PW{1'b0}};
            end else begin
                valid_d = valid_q;
                pay_d   = pay_q;
            end
        end

        // Stage register with asynchronous clear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                pay_q   <= {PW{1'b0}};
            end else begin
                valid_q <= valid_d;
                pay_q   <= pay_d;
            end
        end

        assign stage_valid_s[s] = valid_q;
        assign stage_pay_s[s]   = pay_q;
    end

    assign out_valid = stage_valid_s[STAGES-1];
    assign {out_data, out_tag, out_is_br, out_taken, out_target, out_mispred} = stage_pay_s[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed bench for alu_pipe, checked against a behavioural
// result model plus a per-op latency/stall scoreboard.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int XLEN   = 32;
    localparam int ROB_W  = 4;
    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = 5'd0;
    logic [31:0] in_a = 32'd0, in_b = 32'd0, in_imm = 32'd0, in_pc = 32'd0;
    logic        in_pred_tk = 1'b0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data, out_target;
    logic [3:0]  out_tag;
    logic        out_is_br, out_taken, out_mispred;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ret = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        is_br;
        logic        taken;
        logic [31:0] target;
        logic        mispred;
        int          rem;
    } exp_t;

    exp_t exp_q[$];

    alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_pc(in_pc),
        .in_pred_tk(in_pred_tk), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_is_br(out_is_br), .out_taken(out_taken),
        .out_target(out_target), .out_mispred(out_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // What an op must produce, straight from the RV32I definitions.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic pt, input logic [3:0] tag);
        exp_t e;
        logic cond;
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        cond = 1'b0;
        e.data = 32'd0; e.tag = tag; e.is_br = 1'b0; e.taken = 1'b0;
        e.target = pc4; e.mispred = 1'b0; e.rem = 0;
        case (op)
            OP_ADD:   e.data = a + b;
            OP_SUB:   e.data = a - b;
            OP_AND:   e.data = a & b;
            OP_OR:    e.data = a | b;
            OP_XOR:   e.data = a ^ b;
            OP_ADDI:  e.data = a + imm;
            OP_ANDI:  e.data = a & imm;
            OP_ORI:   e.data = a | imm;
            OP_XORI:  e.data = a ^ imm;
            OP_SLL:   e.data = a << b[4:0];
            OP_SRL:   e.data = a >> b[4:0];
            OP_SRA:   e.data = $signed(a) >>> b[4:0];
            OP_SLLI:  e.data = a << imm[4:0];
            OP_SRLI:  e.data = a >> imm[4:0];
            OP_SRAI:  e.data = $signed(a) >>> imm[4:0];
            OP_SLT:   e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  e.data = (a < b) ? 32'd1 : 32'd0;
            OP_SLTI:  e.data = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTIU: e.data = (a < imm) ? 32'd1 : 32'd0;
            OP_LUI:   e.data = imm;
            OP_AUIPC: e.data = pc + imm;
            OP_BEQ:   begin e.is_br = 1'b1; cond = (a == b); end
            OP_BNE:   begin e.is_br = 1'b1; cond = (a != b); end
            OP_BLT:   begin e.is_br = 1'b1; cond = ($signed(a) < $signed(b)); end
            OP_BGE:   begin e.is_br = 1'b1; cond = ($signed(a) >= $signed(b)); end
            OP_BLTU:  begin e.is_br = 1'b1; cond = (a < b); end
            OP_BGEU:  begin e.is_br = 1'b1; cond = (a >= b); end
            OP_JAL:   begin e.is_br = 1'b1; e.data = pc4; e.taken = 1'b1; e.target = pc + imm; end
            OP_JALR:  begin e.is_br = 1'b1; e.data = pc4; e.taken = 1'b1; e.target = (a + imm) & ~32'd1; end
            default:  e.data = 32'd0;
        endcase
        if (e.is_br && op != OP_JAL && op != OP_JALR) begin
            e.data   = {31'd0, cond};
            e.taken  = cond;
            e.target = cond ? pc + imm : pc4;
        end
        e.mispred = e.is_br && (e.taken != pt);
        return e;
    endfunction

    // Scoreboard: each accepted op appears after STAGES non-stalled cycles, in order.
    always @(negedge clk) begin
        exp_t h;
        bit   ev;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            ev = (exp_q.size() > 0) && (exp_q[0].rem == 0);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(flush || !(ev && !out_ready)));
            if (ev && out_valid) begin
                h = exp_q[0];
                chk("out_data", out_data, h.data);
                chk("out_tag", 32'(out_tag), 32'(h.tag));
                chk("out_is_br", 32'(out_is_br), 32'(h.is_br));
                chk("out_taken", 32'(out_taken), 32'(h.taken));
                chk("out_target", out_target, h.target);
                chk("out_mispred", 32'(out_mispred), 32'(h.mispred));
            end
            if (flush) begin
                exp_q.delete();
            end else if (!(ev && !out_ready)) begin
                if (ev) begin
                    void'(exp_q.pop_front());
                    n_ret++;
                end
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].rem > 0) begin
                        h = exp_q[i];
                        h.rem = h.rem - 1;
                        exp_q[i] = h;
                    end
                end
                if (in_valid) begin
                    h = model(in_op, in_a, in_b, in_imm, in_pc, in_pred_tk, in_tag);
                    h.rem = STAGES - 1;
                    exp_q.push_back(h);
                end
            end
        end
    end

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic pt,
                         input logic [3:0] tag);
        in_op = op; in_a = a; in_b = b; in_imm = imm; in_pc = pc; in_pred_tk = pt; in_tag = tag;
        in_valid = 1'b1;
    endtask

    // Single op through an idle pipe, checked against literal expectations.
    task automatic run_dir(input string nm, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                           input logic pt, input logic [3:0] tag, input logic [31:0] e_data,
                           input logic e_br, input logic e_tk, input logic [31:0] e_tgt,
                           input logic e_mp);
        int lat;
        lat = 0;
        drive(op, a, b, imm, pc, pt, tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(STAGES));
        if (lat != 0) begin
            chk({nm, "_data"}, out_data, e_data);
            chk({nm, "_tag"}, 32'(out_tag), 32'(tag));
            chk({nm, "_is_br"}, 32'(out_is_br), 32'(e_br));
            chk({nm, "_taken"}, 32'(out_taken), 32'(e_tk));
            chk({nm, "_target"}, out_target, e_tgt);
            chk({nm, "_mispred"}, 32'(out_mispred), 32'(e_mp));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    logic [4:0] burst_op [6];
    exp_t       pin;

    initial begin
        int  sent;
        int  base;
        bit  acc;

        // Pin the model itself with hand-worked values.
        pin = model(OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b0, 4'd0);
        chk("model_add", pin.data, 32'd4);
        pin = model(OP_SRA, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 1'b0, 4'd0);
        chk("model_sra", pin.data, 32'hC000_0000);
        pin = model(OP_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 4'd0);
        chk("model_beq_tgt", pin.target, 32'h120);
        chk("model_beq_mp", 32'(pin.mispred), 32'd1);
        pin = model(OP_JALR, 32'h203, 32'd0, 32'd0, 32'h40, 1'b1, 4'd0);
        chk("model_jalr_tgt", pin.target, 32'h202);

        #3;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_target", out_target, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        run_dir("add", OP_ADD, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'h10, 1'b0, 4'd5,
                32'd4, 1'b0, 1'b0, 32'h14, 1'b0);
        run_dir("sra", OP_SRA, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 1'b0, 4'd6,
                32'hC000_0000, 1'b0, 1'b0, 32'd4, 1'b0);
        run_dir("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'd7,
                32'd1, 1'b0, 1'b0, 32'd4, 1'b0);
        run_dir("slt", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 4'd8,
                32'd0, 1'b0, 1'b0, 32'd4, 1'b0);
        run_dir("beq", OP_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 4'd9,
                32'd1, 1'b1, 1'b1, 32'h120, 1'b1);
        run_dir("bne", OP_BNE, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 4'd10,
                32'd0, 1'b1, 1'b0, 32'h104, 1'b0);
        run_dir("jalr", OP_JALR, 32'h203, 32'd0, 32'd0, 32'h40, 1'b1, 4'd11,
                32'h44, 1'b1, 1'b1, 32'h202, 1'b0);
        run_dir("lui", OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'h80, 1'b0, 4'd12,
                32'h1234_5000, 1'b0, 1'b0, 32'h84, 1'b0);
        run_dir("unknown", 5'd31, 32'd9, 32'd9, 32'd9, 32'h200, 1'b0, 4'd13,
                32'd0, 1'b0, 1'b0, 32'h204, 1'b0);

        // Six ops back-to-back with a three-cycle CDB stall in the middle.
        burst_op[0] = OP_ADD;  burst_op[1] = OP_XORI; burst_op[2] = OP_SLL;
        burst_op[3] = OP_BLT;  burst_op[4] = OP_JAL;  burst_op[5] = OP_SLTU;
        base = n_ret;
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 6; cyc++) begin
            drive(burst_op[sent], 32'(sent * 17 + 3), 32'(sent * 5 + 1), 32'(sent * 8),
                  32'(sent * 4096), 1'b1, 4'(sent + 1));
            out_ready = (cyc >= 3 && cyc < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (cyc == 4) chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("burst_retired", 32'(n_ret - base), 32'd6);

        // Random traffic with back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_op      = 5'($urandom_range(0, 31));
            in_a       = $urandom;
            in_b       = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
            in_imm     = $urandom;
            in_pc      = $urandom & 32'hFFFF_FFFC;
            in_pred_tk = 1'($urandom_range(0, 1));
            in_tag     = 4'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Two ops in flight, third offered in the flush cycle: none may appear.
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 4'd1);
        @(posedge clk); #1;
        drive(OP_SUB, 32'd9, 32'd2, 32'd0, 32'd0, 1'b0, 4'd2);
        @(posedge clk); #1;
        drive(OP_OR, 32'd4, 32'd2, 32'd0, 32'd0, 1'b0, 4'd3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_flush_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_dir("after_flush", OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'h300, 1'b0, 4'd14,
                32'hFF00, 1'b0, 1'b0, 32'h304, 1'b0);

        // Asynchronous reset with an op on the output clears it immediately.
        drive(OP_ADDI, 32'd10, 32'd0, 32'd5, 32'd0, 1'b0, 4'd4);
        @(posedge clk); #1;
        drive(OP_ANDI, 32'd10, 32'd0, 32'd6, 32'd0, 1'b0, 4'd5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_dir("after_rst", OP_AUIPC, 32'd0, 32'd0, 32'h1000, 32'h400, 1'b0, 4'd15,
                32'h1400, 1'b0, 1'b0, 32'h404, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
